// File: rtl/vctr_fifo_multiop.sv
// Two-vector FIFO engine: loads vectors A and B, applies an element-wise operation
// through a 2-stage pipeline, accumulates, and returns results via a FWFT output FIFO.
module vctr_fifo_multiop #(
    parameter int DATA_WIDTH       = 16,
    parameter int HSP_BANDS_WIDTH  = 3,
    localparam int OUT_WIDTH       = 2 * DATA_WIDTH,
    localparam int ACC_WIDTH       = OUT_WIDTH + HSP_BANDS_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [HSP_BANDS_WIDTH:0]   hsp_bands,
    input  logic                       data_in_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       data_out_en,
    output logic [OUT_WIDTH-1:0]       data_out,
    output logic                       data_out_valid,
    output logic [ACC_WIDTH-1:0]       acc_out,
    output logic                       idle,
    output logic                       ready,
    output logic                       done
);
    localparam int DEPTH = 2 ** HSP_BANDS_WIDTH;
    localparam int CW    = HSP_BANDS_WIDTH + 1;
    localparam logic [CW-1:0]              DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]              ONE_C   = CW'(1);
    localparam logic [HSP_BANDS_WIDTH-1:0] PTR_ONE = HSP_BANDS_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ_A    = 3'd1,
        ST_READ_B    = 3'd2,
        ST_OPERATION = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 mode_q, mode_d;
    logic [CW-1:0]              n_q, n_d;
    logic [CW-1:0]              wcnt_q, wcnt_d;
    logic [CW-1:0]              rcnt_q, rcnt_d;
    logic                       s1_vld_q;
    logic [DATA_WIDTH-1:0]      s1_a_q, s1_b_q;
    logic [HSP_BANDS_WIDTH-1:0] o_wptr_q, o_rptr_q;
    logic [CW-1:0]              o_cnt_q, o_cnt_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic                       wr_a_s, wr_b_s, pop_ab_s, wr_o_s, pop_o_s;
    logic [OUT_WIDTH-1:0]       res_s;

    logic [DATA_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [DEPTH];
    logic [OUT_WIDTH-1:0]  mem_o [DEPTH];

    // Element-wise operation; operands are zero-extended so no result can wrap.
    function automatic logic [OUT_WIDTH-1:0] calc_result(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        case (op)
            2'd0:    calc_result = OUT_WIDTH'(a) + OUT_WIDTH'(b);
            2'd1:    calc_result = OUT_WIDTH'(diff);
            2'd2:    calc_result = OUT_WIDTH'(diff) * OUT_WIDTH'(diff);
            2'd3:    calc_result = OUT_WIDTH'(a) * OUT_WIDTH'(b);
            default: calc_result = '0;
        endcase
    endfunction

    // Sequencing: job latch, vector load counters, pipeline pop and result drain.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        wr_a_s   = 1'b0;
        wr_b_s   = 1'b0;
        pop_ab_s = 1'b0;
        pop_o_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ_A;
                    mode_d  = mode;
                    n_d     = ((hsp_bands == '0) || (hsp_bands > DEPTH_C)) ? DEPTH_C : hsp_bands;
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_A: begin
                if (data_in_en) begin
                    wr_a_s = 1'b1;
                    if (wcnt_q == n_q - ONE_C) begin
                        wcnt_d  = '0;
                        state_d = ST_READ_B;
                    end else begin
                        wcnt_d = wcnt_q + ONE_C;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            ST_READ_B: begin
                if (data_in_en) begin
                    wr_b_s = 1'b1;
                    if (wcnt_q == n_q - ONE_C) begin
                        wcnt_d  = '0;
                        state_d = ST_OPERATION;
                    end else begin
                        wcnt_d = wcnt_q + ONE_C;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            ST_OPERATION: begin
                if (rcnt_q != n_q) begin
                    pop_ab_s = 1'b1;
                    rcnt_d   = rcnt_q + ONE_C;
                end else begin
                    rcnt_d = rcnt_q;
                end
                // The Nth result is written on this edge, so leave now.
                if (s1_vld_q && (o_cnt_q == n_q - ONE_C)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_OPERATION;
                end
            end
            ST_DONE: begin
                if (data_out_en && (o_cnt_q != '0)) begin
                    pop_o_s = 1'b1;
                    if (o_cnt_q == ONE_C) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pipeline stage 2: result, accumulator and output FIFO occupancy.
    always_comb begin
        res_s   = calc_result(mode_q, s1_a_q, s1_b_q);
        wr_o_s  = s1_vld_q;
        acc_d   = acc_q;
        o_cnt_d = o_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            acc_d = '0;
        end else if (wr_o_s) begin
            acc_d = acc_q + ACC_WIDTH'(res_s);
        end else begin
            acc_d = acc_q;
        end
        if (wr_o_s) begin
            o_cnt_d = o_cnt_q + ONE_C;
        end else if (pop_o_s) begin
            o_cnt_d = o_cnt_q - ONE_C;
        end else begin
            o_cnt_d = o_cnt_q;
        end
    end

    // Control and pipeline registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= 2'd0;
            n_q      <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            o_wptr_q <= '0;
            o_rptr_q <= '0;
            o_cnt_q  <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            n_q      <= n_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            s1_vld_q <= pop_ab_s;
            if (pop_ab_s) begin
                s1_a_q <= mem_a[rcnt_q[HSP_BANDS_WIDTH-1:0]];
                s1_b_q <= mem_b[rcnt_q[HSP_BANDS_WIDTH-1:0]];
            end
            if (wr_o_s) begin
                o_wptr_q <= o_wptr_q + PTR_ONE;
            end
            if (pop_o_s) begin
                o_rptr_q <= o_rptr_q + PTR_ONE;
            end
            o_cnt_q  <= o_cnt_d;
            acc_q    <= acc_d;
        end
    end

    // Storage arrays; occupancy is tracked by the pointers above, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr_a_s) begin
            mem_a[wcnt_q[HSP_BANDS_WIDTH-1:0]] <= data_in;
        end
        if (wr_b_s) begin
            mem_b[wcnt_q[HSP_BANDS_WIDTH-1:0]] <= data_in;
        end
        if (wr_o_s) begin
            mem_o[o_wptr_q] <= res_s;
        end
    end

    assign data_out       = mem_o[o_rptr_q];
    assign data_out_valid = (state_q == ST_DONE) && (o_cnt_q != '0);
    assign acc_out        = acc_q;
    assign idle           = (state_q == ST_IDLE);
    assign ready          = (state_q == ST_READ_A) || (state_q == ST_READ_B);
    assign done           = (state_q == ST_DONE);

endmodule
